// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
// Shares the single D-Cache request port between the MEM stage (port 0) and a
// secondary master (port 1, debug/DMA refill). Port 0 has fixed priority, and a
// starvation counter eventually forces a grant to a waiting port 1. The winning
// request is latched and held on the D-Cache side until dcache_ready.
module dcache_port_arbiter #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 64,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              m0_req_valid,
   input  logic              m0_req_rw,
   input  logic [ADDR_W-1:0] m0_req_addr,
   input  logic [DATA_W-1:0] m0_data_write,
   output logic [DATA_W-1:0] m0_data_read,
   output logic              m0_ready,

   input  logic              m1_req_valid,
   input  logic              m1_req_rw,
   input  logic [ADDR_W-1:0] m1_req_addr,
   input  logic [DATA_W-1:0] m1_data_write,
   output logic [DATA_W-1:0] m1_data_read,
   output logic              m1_ready,

   input  logic              flush_i,

   output logic              dcache_req_valid,
   output logic              dcache_req_rw,
   output logic [ADDR_W-1:0] dcache_req_addr,
   output logic [DATA_W-1:0] dcache_data_write,
   input  logic [DATA_W-1:0] dcache_data_read,
   input  logic              dcache_ready,

   output logic              hold_flag_o
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] starve_cnt;
   logic             m0_can;
   logic             m0_win;
   logic             m1_win;

   // Grant decision, only meaningful while idle; port 1 wins when starved or
   // when port 0 has nothing grantable (absent or blocked by flush).
   always_comb begin
      m0_can = m0_req_valid && !flush_i;
      m0_win = 1'b0;
      m1_win = 1'b0;
      if (state == IDLE) begin
         if (m1_req_valid && ((starve_cnt == CNT_MAX) || !m0_can)) begin
            m1_win = 1'b1;
         end else if (m0_can) begin
            m0_win = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: a granted transaction always runs to dcache_ready
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (m1_win) begin
               state_nxt = BUSY1;
            end else if (m0_win) begin
               state_nxt = BUSY0;
            end
         end
         BUSY0, BUSY1: begin
            if (dcache_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Latch the winner's request at the grant edge; held until the next grant
   always_ff @(posedge clk) begin
      if (rst) begin
         dcache_req_rw     <= 1'b0;
         dcache_req_addr   <= '0;
         dcache_data_write <= '0;
      end else if (m1_win) begin
         dcache_req_rw     <= m1_req_rw;
         dcache_req_addr   <= m1_req_addr;
         dcache_data_write <= m1_data_write;
      end else if (m0_win) begin
         dcache_req_rw     <= m0_req_rw;
         dcache_req_addr   <= m0_req_addr;
         dcache_data_write <= m0_data_write;
      end
   end

   // Starvation counter: counts port-0 grants taken while port 1 is waiting
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!m1_req_valid || m1_win) begin
         starve_cnt <= '0;
      end else if (m0_win && (starve_cnt != CNT_MAX)) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   // Output decode: ready and read data only reach the port that owns the cache
   always_comb begin
      dcache_req_valid = (state != IDLE);
      m0_ready         = dcache_ready && (state == BUSY0);
      m1_ready         = dcache_ready && (state == BUSY1);
      m0_data_read     = (state == BUSY0) ? dcache_data_read : '0;
      m1_data_read     = (state == BUSY1) ? dcache_data_read : '0;
      hold_flag_o      = m0_req_valid && !m0_ready;
   end

endmodule
